// File: rtl/dp_sram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port SRAM.
// Lane merge is sized for the widest supported word and truncated by users.
package dp_sram_pkg;

  localparam bit RDW_OLD = 1'b0;
  localparam bit RDW_NEW = 1'b1;

  localparam int MRG_W  = 1024;
  localparam int MRG_BE = MRG_W / 8;

  typedef enum logic {
    CLEAR,
    READY
  } ctl_state_e;

  function automatic logic [MRG_W-1:0] lane_merge(
    input logic [MRG_W-1:0]  old_w,
    input logic [MRG_W-1:0]  new_w,
    input logic [MRG_BE-1:0] be
  );
    logic [MRG_W-1:0] res;
    res = old_w;
    for (int k = 0; k < MRG_BE; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_sram_clr_seq.sv
// Post-reset clear sequencer: walks every word once, then flags ready.
// Holds at index 0 with no write while reset is held low.
module dp_sram_clr_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);
  import dp_sram_pkg::*;

  ctl_state_e        state;
  logic [ADDR_W-1:0] clr_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_idx <= clr_idx + ADDR_W'(1);
          if (clr_idx == '1) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: begin
          init_done <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR) & rst;
  assign clr_addr = clr_idx;

endmodule

// File: rtl/dp_sram_be.sv
// True dual-port SRAM with byte enables, port-A write priority,
// selectable cross-port read-during-write and a hardware clear.
module dp_sram_be #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  output logic                collision,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   wdata_a,
  output logic [DATA_W-1:0]   rdata_a,
  output logic                rvalid_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   wdata_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                rvalid_b
);
  import dp_sram_pkg::*;

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  dp_sram_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .init_done(init_done)
  );

  function automatic logic [DATA_W-1:0] mrg(
    input logic [DATA_W-1:0] o,
    input logic [DATA_W-1:0] n,
    input logic [BE_W-1:0]   b
  );
    return DATA_W'(lane_merge(MRG_W'(o), MRG_W'(n), MRG_BE'(b)));
  endfunction

  logic rd_a, rd_b, wr_a, wr_b, same;
  assign rd_a = init_done & en_a & ~we_a;
  assign rd_b = init_done & en_b & ~we_b;
  assign wr_a = init_done & en_a & we_a;
  assign wr_b = init_done & en_b & we_b;
  assign same = (addr_a == addr_b);

  // The clear sequencer borrows the port-A write path.
  logic              pa_we;
  logic [ADDR_W-1:0] pa_addr;
  logic [BE_W-1:0]   pa_be;
  logic [DATA_W-1:0] pa_wdata;
  assign pa_we    = clr_we | wr_a;
  assign pa_addr  = clr_we ? clr_addr : addr_a;
  assign pa_be    = clr_we ? '1 : be_a;
  assign pa_wdata = clr_we ? '0 : wdata_a;

  // Port A lanes are written last so they win on a shared address.
  always_ff @(posedge clk) begin
    for (int k = 0; k < BE_W; k++) begin
      if (wr_b && be_b[k])
        mem[addr_b][8*k +: 8] <= wdata_b[8*k +: 8];
      if (pa_we && pa_be[k])
        mem[pa_addr][8*k +: 8] <= pa_wdata[8*k +: 8];
    end
  end

  logic [DATA_W-1:0] thru_a, thru_b;
  always_comb begin
    thru_a = mem[addr_a];
    thru_b = mem[addr_b];
    if (RDW_MODE == int'(RDW_NEW)) begin
      if (wr_b && same) thru_a = mrg(mem[addr_a], wdata_b, be_b);
      if (wr_a && same) thru_b = mrg(mem[addr_b], wdata_a, be_a);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_a   <= '0;
      rdata_b   <= '0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      collision <= 1'b0;
    end else begin
      rvalid_a  <= rd_a;
      rvalid_b  <= rd_b;
      collision <= init_done & en_a & en_b & same & (we_a | we_b);
      if (rd_a) rdata_a <= thru_a;
      if (rd_b) rdata_b <= thru_b;
    end
  end

endmodule

// File: tb/tb_dp_sram_be.sv
// Bench for dp_sram_be: both RDW modes side by side against a word-array
// model, directed scenarios followed by randomized traffic.
module tb_dp_sram_be;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [1:0]  be_a = '0, be_b = '0;
  logic [7:0]  addr_a = '0, addr_b = '0;
  logic [15:0] wdata_a = '0, wdata_b = '0;

  logic        init0, col0, rva0, rvb0;
  logic        init1, col1, rva1, rvb1;
  logic [15:0] ra0, rb0, ra1, rb1;

  always #5 clk = ~clk;

  dp_sram_be #(.DATA_W(16), .ADDR_W(8), .RDW_MODE(0)) u_old (
    .clk(clk), .rst(rst), .init_done(init0), .collision(col0),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .wdata_a(wdata_a), .rdata_a(ra0), .rvalid_a(rva0),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
    .wdata_b(wdata_b), .rdata_b(rb0), .rvalid_b(rvb0)
  );

  dp_sram_be #(.DATA_W(16), .ADDR_W(8), .RDW_MODE(1)) u_new (
    .clk(clk), .rst(rst), .init_done(init1), .collision(col1),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .wdata_a(wdata_a), .rdata_a(ra1), .rvalid_a(rva1),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
    .wdata_b(wdata_b), .rdata_b(rb1), .rvalid_b(rvb1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0] mem_m [DEPTH];
  bit          ready_m = 0;
  int          clr_cnt = 0;
  logic        e_init = 0, e_col = 0, e_rva = 0, e_rvb = 0;
  logic [15:0] e_ra0 = 0, e_ra1 = 0, e_rb0 = 0, e_rb1 = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] pre_a, pre_b;
    bit wa, wb;
    if (!rst) begin
      ready_m = 0; clr_cnt = 0;
      e_init = 0; e_col = 0; e_rva = 0; e_rvb = 0;
      e_ra0 = 0; e_ra1 = 0; e_rb0 = 0; e_rb1 = 0;
    end else if (!ready_m) begin
      mem_m[clr_cnt] = 16'h0000;
      clr_cnt++;
      e_col = 0; e_rva = 0; e_rvb = 0;
      if (clr_cnt == DEPTH) begin
        ready_m = 1; e_init = 1;
      end
    end else begin
      pre_a = mem_m[addr_a];
      pre_b = mem_m[addr_b];
      wa = en_a && we_a;
      wb = en_b && we_b;
      for (int k = 0; k < 2; k++) begin
        if (wb && be_b[k]) mem_m[addr_b][8*k +: 8] = wdata_b[8*k +: 8];
        if (wa && be_a[k]) mem_m[addr_a][8*k +: 8] = wdata_a[8*k +: 8];
      end
      e_rva = en_a && !we_a;
      e_rvb = en_b && !we_b;
      if (e_rva) begin e_ra0 = pre_a; e_ra1 = mem_m[addr_a]; end
      if (e_rvb) begin e_rb0 = pre_b; e_rb1 = mem_m[addr_b]; end
      e_col = en_a && en_b && (addr_a == addr_b) && (wa || wb);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("init_old", init0, e_init);
    chk("init_new", init1, e_init);
    chk("coll_old", col0, e_col);
    chk("coll_new", col1, e_col);
    chk("rva_old", rva0, e_rva);
    chk("rvb_old", rvb0, e_rvb);
    chk("rva_new", rva1, e_rva);
    chk("rvb_new", rvb1, e_rvb);
    chk("ra_old", ra0, e_ra0);
    chk("rb_old", rb0, e_rb0);
    chk("ra_new", ra1, e_ra1);
    chk("rb_new", rb1, e_rb1);
  endtask

  task automatic set_a(input logic en, input logic we, input logic [1:0] be,
                       input logic [7:0] ad, input logic [15:0] d);
    en_a = en; we_a = we; be_a = be; addr_a = ad; wdata_a = d;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [1:0] be,
                       input logic [7:0] ad, input logic [15:0] d);
    en_b = en; we_b = we; be_b = be; addr_b = ad; wdata_b = d;
  endtask

  task automatic idle();
    set_a(0, 0, 2'b00, 8'h00, 16'h0000);
    set_b(0, 0, 2'b00, 8'h00, 16'h0000);
  endtask

  task automatic rnd(input int amax);
    set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 8'($urandom_range(0, amax)),
          16'($urandom));
    set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 8'($urandom_range(0, amax)),
          16'($urandom));
  endtask

  initial begin
    int n;
    int pulses;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'hxxxx;

    // Reset held for three cycles
    rst = 0; idle();
    repeat (3) step();

    // Clear with port traffic that must be ignored
    rst = 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 200) set_a(1, 1, 2'b11, 8'h7F, 16'hFFFF);
      else rnd(255);
      step();
    end
    chk("init_after_clear", init0, 1'b1);

    idle(); set_a(1, 0, 2'b00, 8'h7F, 16'h0);
    step();
    chk("rd_7f_zero", ra0, 16'h0000);
    idle(); step();

    // Byte enables
    set_a(1, 1, 2'b11, 8'h05, 16'hBEEF); step();
    set_a(1, 1, 2'b10, 8'h05, 16'h1234); step();
    set_a(1, 0, 2'b00, 8'h05, 16'h0000); step();
    chk("be_rdata", ra0, 16'h12EF);
    chk("be_rvalid", rva0, 1'b1);
    idle(); step();
    chk("be_rvalid_pulse", rva0, 1'b0);

    // Write/write collision
    set_a(1, 1, 2'b01, 8'h09, 16'hAAAA);
    set_b(1, 1, 2'b11, 8'h09, 16'hBBBB);
    step();
    chk("ww_coll", col0, 1'b1);
    idle(); set_a(1, 0, 2'b00, 8'h09, 16'h0); step();
    chk("ww_data", ra0, 16'hBBAA);
    chk("ww_coll_once", col0, 1'b0);
    idle(); step();

    // Read during write
    set_a(1, 1, 2'b11, 8'h03, 16'h1111); step();
    set_a(1, 1, 2'b11, 8'h03, 16'h2222);
    set_b(1, 0, 2'b00, 8'h03, 16'h0000);
    step();
    chk("rdw_old", rb0, 16'h1111);
    chk("rdw_new", rb1, 16'h2222);
    chk("rdw_coll_old", col0, 1'b1);
    chk("rdw_coll_new", col1, 1'b1);
    idle(); step();

    // Independent streaming
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      set_a(1, 0, 2'b00, 8'(i), 16'h0);
      set_b(1, 1, 2'b11, 8'(16 + i), 16'($urandom));
      step();
      if (rva0 === 1'b1) pulses++;
    end
    chk("stream_pulses", pulses, 16);
    idle(); step();

    // Random traffic on a small window to provoke collisions
    for (int i = 0; i < 300; i++) begin
      rnd(7);
      step();
    end
    for (int i = 0; i < 60; i++) begin
      rnd(31);
      step();
    end

    // Reset in the middle of a clear
    idle(); rst = 0; step();
    rst = 1;
    repeat (100) step();
    rst = 0; step(); step();
    rst = 1;
    n = 0;
    while (init0 !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("reclear_cycles", n, 256);
    set_a(1, 0, 2'b00, 8'h05, 16'h0); step();
    chk("reclear_data", ra0, 16'h0000);
    idle(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
